uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Byte-level UART transmitter; directly downstream of the 16-bit tx control stage.
//  Accepts one byte per tx_start/tx_busy handshake and serialises it LSB-first.
//  Frame: start bit (0), 8 data bits, optional parity, 1 or 2 stop bits (1).
//  Output tx drives the board UART pin; tx_busy paces the upstream byte sequencer.
// PARAMETERS
//  CLK_FREQ   100_000_000  system clock frequency in Hz
//  BAUD_RATE  115_200      line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer div, >=2)
//  PARITY     0            0 = none, 1 = odd, 2 = even
//  STOP_BITS  1            1 or 2 stop bits
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  reset     in   1  synchronous, active-high reset
//  tx_start  in   1  request to send tx_data; sampled only in IDLE
//  tx_data   in   8  byte to send; sampled in the same cycle as tx_start
//  tx        out  1  serial line, idle high
//  tx_busy   out  1  high while a frame is in progress (registered)
// BEHAVIOUR
//  - Reset: tx=1, tx_busy=0, state=IDLE, bit/baud counters=0, shift reg=0.
//  - Reset mid-frame aborts: next edge tx=1, tx_busy=0; no partial stop bit.
//  - FSM states: IDLE -> START -> DATA -> PARITY (only if PARITY!=0) -> STOP -> IDLE.
//  - IDLE: tx=1, tx_busy=0. If tx_start=1: latch tx_data, go to START.
//    Latency: start bit appears on tx the cycle after tx_start is sampled.
//  - tx_busy=1 in every non-IDLE state, so it is high the cycle after acceptance.
//  - Each bit is held exactly CLKS_PER_BIT cycles. The baud counter runs
//    0..CLKS_PER_BIT-1, clears on entry to START, and wraps at each bit boundary.
//    Width: $clog2(CLKS_PER_BIT).
//  - DATA: tx = shreg[0]; shift right at each bit end. A 3-bit index counts 0..7;
//    leave DATA when index=7 and the baud counter wraps.
//  - PARITY: even = ^data, odd = ~^data; computed from the latched byte.
//  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
//  - Frame length: (1+8+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles with tx_busy=1.
//  - After STOP, IDLE is held for at least 1 cycle (tx_busy=0) before the next
//    tx_start can be accepted. A held tx_start therefore produces frames separated
//    by exactly 1 idle cycle.
//  - tx_start while busy is ignored: not queued, latched byte unchanged.
//  - tx is driven from a register (no combinational glitches on the pin).
//  - Illegal parameters (CLKS_PER_BIT<2, PARITY>2, STOP_BITS not 1/2):
//    elaboration-time $error.
// STRUCTURE
//  - uart_pkg: state enum uart_tx_state_t {IDLE,START,DATA,PARITY,STOP};
//    localparams PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2; function clks_per_bit().
//    Shared with the future uart_rx.
//  - Sub-module baud_counter (#WIDTH, MAX): inputs clr and en; output tick on wrap.
//    The same sub-module will be reused in the receiver.
// TESTING (CLK_FREQ=8, BAUD_RATE=2 -> CLKS_PER_BIT=4 unless noted)
//  1 Reset held 3 cycles, then released -> tx=1, tx_busy=0 throughout; no frame.
//  2 tx_data=8'hA5, 1-cycle tx_start -> tx = 0,1,0,1,0,0,1,0,1,1, each held
//    4 cycles; tx_busy=1 for exactly 40 cycles.
//  3 PARITY=2, tx_data=8'h07 -> parity bit 1; PARITY=1 with the same byte -> 0;
//    frame is 44 cycles.
//  4 tx_start with 8'h3C issued 10 cycles into the A5 frame -> ignored; only A5 is
//    sent; tx_busy falls after 40 cycles.
//  5 reset asserted during data bit 3 -> next edge tx=1, tx_busy=0; a new tx_start
//    then sends a full, clean frame.
//  6 tx_start held high, tx_data=8'h55 -> back-to-back frames: 40 busy cycles,
//    1 idle cycle (tx=1, busy=0), 40 busy cycles; STOP_BITS=2 gives 44-cycle frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selectors and baud helper.
// Intended for both the transmitter and the future receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_tx_state_t;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/baud_counter.sv
// Free-running bit-period counter: counts 0..MAX while enabled, pulses tick on wrap.
module baud_counter #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned MAX   = 3
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_o = en_i && (cnt_q == MaxCnt);
      cnt_d  = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-level UART transmitter: start bit, 8 data bits LSB-first, optional parity,
// 1 or 2 stop bits. tx and tx_busy are both registered.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter int unsigned BAUD_RATE = 115_200,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       tx_start_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_o,
   output logic       tx_busy_o
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int unsigned CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
   end
   if (PARITY > 2) begin : g_bad_parity
      $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
   end

   uart_tx_state_t state_q, state_d;
   logic [7:0]     data_q, data_d;
   logic [7:0]     shreg_q, shreg_d;
   logic [2:0]     idx_q, idx_d;
   logic           tx_q, tx_d;
   logic           busy_q, busy_d;
   logic           baud_clr, baud_en, baud_tick;
   logic           parity_bit;

   baud_counter #(
      .WIDTH (CNT_W),
      .MAX   (CLKS_PER_BIT - 1)
   ) u_baud_counter (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (baud_clr),
      .en_i    (baud_en),
      .tick_o  (baud_tick)
   );

   // Held at zero through IDLE so START always begins a full bit period.
   assign baud_clr = (state_q == StIdle);
   assign baud_en  = (state_q != StIdle);

   assign parity_bit = (PARITY == PAR_ODD) ? ~^data_q : ^data_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      case (state_q)
         StIdle: begin
            if (tx_start_i) begin
               data_d  = tx_data_i;
               shreg_d = tx_data_i;
               idx_d   = 3'd0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (baud_tick) begin
               idx_d   = 3'd0;
               state_d = StData;
            end
         end
         StData: begin
            if (baud_tick) begin
               shreg_d = {1'b0, shreg_q[7:1]};
               if (idx_q == 3'd7) begin
                  idx_d   = 3'd0;
                  state_d = (PARITY != PAR_NONE) ? StParity : StStop;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         StParity: begin
            if (baud_tick) begin
               idx_d   = 3'd0;
               state_d = StStop;
            end
         end
         StStop: begin
            // idx_q counts stop bits here.
            if (baud_tick) begin
               if (idx_q == 3'(STOP_BITS - 1)) begin
                  idx_d   = 3'd0;
                  state_d = StIdle;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Line level is derived from the next state so the pin flop tracks state_q exactly.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_d != StIdle);
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shreg_d[0];
         StParity: tx_d = parity_bit;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         data_q  <= '0;
         shreg_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   assign tx_o      = tx_q;
   assign tx_busy_o = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: four DUT configurations (none/even/odd parity, two stop bits),
// CLKS_PER_BIT = 4, checking tx and tx_busy every cycle against hand-built frames.
module tb_uart_tx_serializer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start [4];
   logic [7:0] data  [4];
   logic       tx    [4];
   logic       busy  [4];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_tx_serializer #(.CLK_FREQ(8), .BAUD_RATE(2), .PARITY(0), .STOP_BITS(1)) u_dut_none (
      .clk_i(clk), .reset_i(reset), .tx_start_i(start[0]), .tx_data_i(data[0]),
      .tx_o(tx[0]), .tx_busy_o(busy[0]));
   uart_tx_serializer #(.CLK_FREQ(8), .BAUD_RATE(2), .PARITY(2), .STOP_BITS(1)) u_dut_even (
      .clk_i(clk), .reset_i(reset), .tx_start_i(start[1]), .tx_data_i(data[1]),
      .tx_o(tx[1]), .tx_busy_o(busy[1]));
   uart_tx_serializer #(.CLK_FREQ(8), .BAUD_RATE(2), .PARITY(1), .STOP_BITS(1)) u_dut_odd (
      .clk_i(clk), .reset_i(reset), .tx_start_i(start[2]), .tx_data_i(data[2]),
      .tx_o(tx[2]), .tx_busy_o(busy[2]));
   uart_tx_serializer #(.CLK_FREQ(8), .BAUD_RATE(2), .PARITY(0), .STOP_BITS(2)) u_dut_stop2 (
      .clk_i(clk), .reset_i(reset), .tx_start_i(start[3]), .tx_data_i(data[3]),
      .tx_o(tx[3]), .tx_busy_o(busy[3]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 4; k++) begin
         start[k] = 1'b0;
         data[k]  = 8'h00;
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         for (int k = 0; k < 4; k++) begin
            total++;
            if ({busy[k], tx[k]} !== 2'b01) begin
               bad++;
               $display("FAIL reset_hold dut=%0d cyc=%0d busy,tx=%b want 01", k, i, {busy[k], tx[k]});
            end
         end
      end
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         for (int k = 0; k < 4; k++) begin
            total++;
            if ({busy[k], tx[k]} !== 2'b01) begin
               bad++;
               $display("FAIL reset_release dut=%0d cyc=%0d busy,tx=%b want 01", k, i,
                        {busy[k], tx[k]});
            end
         end
      end
   endtask

   task automatic test_basic_a5();
      logic [9:0] bits;
      bits = 10'b1101001010;
      data[0]  = 8'hA5;
      start[0] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (c == 0) start[0] = 1'b0;
         total++;
         if ({busy[0], tx[0]} !== {1'b1, bits[c/4]}) begin
            bad++;
            $display("FAIL a5_frame cyc=%0d busy,tx=%b want %b", c, {busy[0], tx[0]},
                     {1'b1, bits[c/4]});
         end
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({busy[0], tx[0]} !== 2'b01) begin
            bad++;
            $display("FAIL a5_end cyc=%0d busy,tx=%b want 01", i, {busy[0], tx[0]});
         end
      end
   endtask

   task automatic test_parity();
      logic [10:0] even_bits;
      logic [10:0] odd_bits;
      even_bits = 11'b11000001110;
      odd_bits  = 11'b10000001110;
      data[1] = 8'h07;
      data[2] = 8'h07;
      start[1] = 1'b1;
      start[2] = 1'b1;
      for (int c = 0; c < 44; c++) begin
         tick();
         if (c == 0) begin
            start[1] = 1'b0;
            start[2] = 1'b0;
         end
         total++;
         if ({busy[1], tx[1]} !== {1'b1, even_bits[c/4]}) begin
            bad++;
            $display("FAIL even_frame cyc=%0d busy,tx=%b want %b", c, {busy[1], tx[1]},
                     {1'b1, even_bits[c/4]});
         end
         total++;
         if ({busy[2], tx[2]} !== {1'b1, odd_bits[c/4]}) begin
            bad++;
            $display("FAIL odd_frame cyc=%0d busy,tx=%b want %b", c, {busy[2], tx[2]},
                     {1'b1, odd_bits[c/4]});
         end
      end
      tick();
      total++;
      if ({busy[1], tx[1], busy[2], tx[2]} !== 4'b0101) begin
         bad++;
         $display("FAIL parity_end busy,tx even/odd=%b want 0101",
                  {busy[1], tx[1], busy[2], tx[2]});
      end
   endtask

   task automatic test_busy_ignore();
      logic [9:0] bits;
      bits = 10'b1101001010;
      data[0]  = 8'hA5;
      start[0] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (c == 0) start[0] = 1'b0;
         if (c == 9) begin
            start[0] = 1'b1;
            data[0]  = 8'h3C;
         end
         if (c == 10) start[0] = 1'b0;
         total++;
         if ({busy[0], tx[0]} !== {1'b1, bits[c/4]}) begin
            bad++;
            $display("FAIL ignore_frame cyc=%0d busy,tx=%b want %b", c, {busy[0], tx[0]},
                     {1'b1, bits[c/4]});
         end
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if ({busy[0], tx[0]} !== 2'b01) begin
            bad++;
            $display("FAIL ignore_not_queued cyc=%0d busy,tx=%b want 01", i, {busy[0], tx[0]});
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [9:0] a5_bits;
      logic [9:0] c3_bits;
      a5_bits = 10'b1101001010;
      c3_bits = 10'b1001111000;
      data[0]  = 8'hA5;
      start[0] = 1'b1;
      // Cycles 16..19 carry data bit 3; reset lands in the middle of it.
      for (int c = 0; c < 18; c++) begin
         tick();
         if (c == 0) start[0] = 1'b0;
         total++;
         if ({busy[0], tx[0]} !== {1'b1, a5_bits[c/4]}) begin
            bad++;
            $display("FAIL abort_pre cyc=%0d busy,tx=%b want %b", c, {busy[0], tx[0]},
                     {1'b1, a5_bits[c/4]});
         end
      end
      reset = 1'b1;
      tick();
      total++;
      if ({busy[0], tx[0]} !== 2'b01) begin
         bad++;
         $display("FAIL abort_edge busy,tx=%b want 01", {busy[0], tx[0]});
      end
      reset = 1'b0;
      tick();
      total++;
      if ({busy[0], tx[0]} !== 2'b01) begin
         bad++;
         $display("FAIL abort_idle busy,tx=%b want 01", {busy[0], tx[0]});
      end
      data[0]  = 8'h3C;
      start[0] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (c == 0) start[0] = 1'b0;
         total++;
         if ({busy[0], tx[0]} !== {1'b1, c3_bits[c/4]}) begin
            bad++;
            $display("FAIL abort_refill cyc=%0d busy,tx=%b want %b", c, {busy[0], tx[0]},
                     {1'b1, c3_bits[c/4]});
         end
      end
      tick();
      total++;
      if ({busy[0], tx[0]} !== 2'b01) begin
         bad++;
         $display("FAIL abort_refill_end busy,tx=%b want 01", {busy[0], tx[0]});
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] bits;
      int          d;
      int          len;
      bits = 11'b11010101010;
      for (int k = 0; k < 2; k++) begin
         d   = (k == 0) ? 0 : 3;
         len = (k == 0) ? 40 : 44;
         data[d]  = 8'h55;
         start[d] = 1'b1;
         for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < len; c++) begin
               tick();
               if (f == 1 && c == len - 1) start[d] = 1'b0;
               total++;
               if ({busy[d], tx[d]} !== {1'b1, bits[c/4]}) begin
                  bad++;
                  $display("FAIL b2b_frame dut=%0d frame=%0d cyc=%0d busy,tx=%b want %b", d, f, c,
                           {busy[d], tx[d]}, {1'b1, bits[c/4]});
               end
            end
            tick();
            total++;
            if ({busy[d], tx[d]} !== 2'b01) begin
               bad++;
               $display("FAIL b2b_gap dut=%0d frame=%0d busy,tx=%b want 01", d, f,
                        {busy[d], tx[d]});
            end
         end
         tick();
         total++;
         if ({busy[d], tx[d]} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_stop dut=%0d busy,tx=%b want 01", d, {busy[d], tx[d]});
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_a5();
      test_parity();
      test_busy_ignore();
      test_reset_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
